// File: rtl/writeback_tracker_pkg.sv
// Shared pipeline types and constants for the DM1..WB writeback tracker.
package writeback_tracker_pkg;

  localparam int unsigned PIPE_DATA_WIDTH   = 32;
  localparam int unsigned PIPE_ADDR_WIDTH   = 5;
  localparam int unsigned NUM_STAGES        = 4;
  localparam int unsigned STALL_COUNT_WIDTH = 32;

  typedef logic [1:0] stage_idx_t;

  localparam stage_idx_t DM1 = 2'd0;
  localparam stage_idx_t DM2 = 2'd1;
  localparam stage_idx_t DM3 = 2'd2;
  localparam stage_idx_t WB  = 2'd3;

  localparam logic [PIPE_ADDR_WIDTH-1:0] X0_ADDR = '0;

  // One in-flight instruction as tracked from DM1 through WB
  typedef struct packed {
    logic                       valid;
    logic                       write;
    logic                       is_load;
    logic [PIPE_ADDR_WIDTH-1:0] rd;
    logic [PIPE_DATA_WIDTH-1:0] data;
  } stage_t;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard check of the EX sources against loads in DM1/DM2.
module load_use_detector #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  ex_valid,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] rs1_address,
  input  logic [ADDR_WIDTH-1:0] rs2_address,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  dm1_load_live,
  input  logic [ADDR_WIDTH-1:0] dm1_rd,
  input  logic                  dm2_load_live,
  input  logic [ADDR_WIDTH-1:0] dm2_rd,
  output logic                  stall_c
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 never carries a dependency, so it cannot cause a stall
  assign rs1_hit = rs1_used && (rs1_address != '0) &&
                   ((dm1_load_live && (rs1_address == dm1_rd)) ||
                    (dm2_load_live && (rs1_address == dm2_rd)));
  assign rs2_hit = rs2_used && (rs2_address != '0) &&
                   ((dm1_load_live && (rs2_address == dm1_rd)) ||
                    (dm2_load_live && (rs2_address == dm2_rd)));

  // A flushed instruction is dead, so flush always wins over a stall
  assign stall_c = ex_valid && !flush && (rs1_hit || rs2_hit);

endmodule

// File: rtl/writeback_tracker.sv
// Tracks instructions through DM1/DM2/DM3/WB, exposes forwarding info and load-use stalls.
// Optional stall-cycle counter enabled by defining WRITEBACK_TRACKER_STALL_COUNT_EN.
module writeback_tracker
  import writeback_tracker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PIPE_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = PIPE_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ex_valid,
  input  logic                         ex_rd_write,
  input  logic                         ex_is_load,
  input  logic [ADDR_WIDTH-1:0]        ex_rd_address,
  input  logic [DATA_WIDTH-1:0]        ex_result,
  input  logic [ADDR_WIDTH-1:0]        ex_rs1_address,
  input  logic [ADDR_WIDTH-1:0]        ex_rs2_address,
  input  logic                         ex_rs1_used,
  input  logic                         ex_rs2_used,
  input  logic                         flush,
  input  logic [DATA_WIDTH-1:0]        load_data_dm3,
  output logic [ADDR_WIDTH-1:0]        rd_address_dm1,
  output logic [ADDR_WIDTH-1:0]        rd_address_dm2,
  output logic [ADDR_WIDTH-1:0]        rd_address_dm3,
  output logic [ADDR_WIDTH-1:0]        rd_address_wb,
  output logic [DATA_WIDTH-1:0]        rd_data_dm1,
  output logic [DATA_WIDTH-1:0]        rd_data_dm2,
  output logic [DATA_WIDTH-1:0]        rd_data_dm3,
  output logic [DATA_WIDTH-1:0]        rd_data_wb,
  output logic                         rf_write_en,
  output logic [ADDR_WIDTH-1:0]        rf_write_address,
  output logic [DATA_WIDTH-1:0]        rf_write_data,
  output logic                         stall_ex,
  output logic [STALL_COUNT_WIDTH-1:0] stall_count
);

  stage_t stage_q [NUM_STAGES];
  stage_t dm1_d;
  stage_t wb_d;
  logic   dm1_load_live;
  logic   dm2_load_live;

  // A dead stage or an x0 destination must never look like a forwarding source
  function automatic logic [ADDR_WIDTH-1:0] out_addr(input stage_t s);
    return (s.valid && s.write) ? ADDR_WIDTH'(s.rd) : '0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] out_data(input stage_t s,
                                                     input logic [DATA_WIDTH-1:0] load_value);
    if (!(s.valid && s.write) || (s.rd == X0_ADDR)) return '0;
    if (s.is_load) return load_value;
    return DATA_WIDTH'(s.data);
  endfunction

  assign dm1_load_live = stage_q[DM1].valid && stage_q[DM1].write && stage_q[DM1].is_load;
  assign dm2_load_live = stage_q[DM2].valid && stage_q[DM2].write && stage_q[DM2].is_load;

  load_use_detector #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_load_use_detector (
    .ex_valid      (ex_valid),
    .flush         (flush),
    .rs1_address   (ex_rs1_address),
    .rs2_address   (ex_rs2_address),
    .rs1_used      (ex_rs1_used),
    .rs2_used      (ex_rs2_used),
    .dm1_load_live (dm1_load_live),
    .dm1_rd        (ADDR_WIDTH'(stage_q[DM1].rd)),
    .dm2_load_live (dm2_load_live),
    .dm2_rd        (ADDR_WIDTH'(stage_q[DM2].rd)),
    .stall_c       (stall_ex)
  );

  // DM1 capture: a stalled or flushed EX slot enters as a bubble
  always_comb begin
    dm1_d = '0;
    if (ex_valid && !flush && !stall_ex) begin
      dm1_d.valid   = 1'b1;
      dm1_d.write   = ex_rd_write;
      dm1_d.is_load = ex_is_load;
      dm1_d.rd      = PIPE_ADDR_WIDTH'(ex_rd_address);
      dm1_d.data    = PIPE_DATA_WIDTH'(ex_result);
    end
  end

  // Loads pick up their memory data on the way from DM3 into WB
  always_comb begin
    wb_d = stage_q[DM3];
    if (stage_q[DM3].is_load) begin
      wb_d.data = PIPE_DATA_WIDTH'(load_data_dm3);
    end
  end

  // The stage chain never freezes; stalls only insert bubbles at DM1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q[DM1] <= '0;
      stage_q[DM2] <= '0;
      stage_q[DM3] <= '0;
      stage_q[WB]  <= '0;
    end else begin
      stage_q[DM1] <= dm1_d;
      stage_q[DM2] <= stage_q[DM1];
      stage_q[DM3] <= stage_q[DM2];
      stage_q[WB]  <= wb_d;
    end
  end

  assign rd_address_dm1 = out_addr(stage_q[DM1]);
  assign rd_address_dm2 = out_addr(stage_q[DM2]);
  assign rd_address_dm3 = out_addr(stage_q[DM3]);
  assign rd_address_wb  = out_addr(stage_q[WB]);

  assign rd_data_dm1 = out_data(stage_q[DM1], '0);
  assign rd_data_dm2 = out_data(stage_q[DM2], '0);
  assign rd_data_dm3 = out_data(stage_q[DM3], load_data_dm3);
  assign rd_data_wb  = out_data(stage_q[WB], DATA_WIDTH'(stage_q[WB].data));

  assign rf_write_en      = stage_q[WB].valid && stage_q[WB].write && (stage_q[WB].rd != X0_ADDR);
  assign rf_write_address = ADDR_WIDTH'(stage_q[WB].rd);
  assign rf_write_data    = DATA_WIDTH'(stage_q[WB].data);

`ifdef WRITEBACK_TRACKER_STALL_COUNT_EN
  logic [STALL_COUNT_WIDTH-1:0] stall_count_q;

  // Saturating count of cycles spent stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (stall_ex && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + STALL_COUNT_WIDTH'(1);
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_writeback_tracker.sv
// Directed table-driven bench for writeback_tracker plus reset/latency sequences.
module tb_writeback_tracker;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NV = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, ex_rd_write, ex_is_load, ex_rs1_used, ex_rs2_used, flush;
  logic [AW-1:0] ex_rd_address, ex_rs1_address, ex_rs2_address;
  logic [DW-1:0] ex_result, load_data_dm3;
  logic [AW-1:0] rd_address_dm1, rd_address_dm2, rd_address_dm3, rd_address_wb;
  logic [DW-1:0] rd_data_dm1, rd_data_dm2, rd_data_dm3, rd_data_wb;
  logic          rf_write_en, stall_ex;
  logic [AW-1:0] rf_write_address;
  logic [DW-1:0] rf_write_data;
  logic [31:0]   stall_count;

  int checks = 0;
  int errors = 0;

  // Inputs for one cycle, then the outputs expected just before that cycle's edge
  typedef struct {
    logic [31:0] v, w, ld, rd, res, rs1, rs2, u1, u2, fl, lm;
    logic [31:0] st, a1, a2, a3, aw, d1, d2, d3, dw, we;
  } vec_t;

  vec_t tbl [NV];

  writeback_tracker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_rd_write      (ex_rd_write),
    .ex_is_load       (ex_is_load),
    .ex_rd_address    (ex_rd_address),
    .ex_result        (ex_result),
    .ex_rs1_address   (ex_rs1_address),
    .ex_rs2_address   (ex_rs2_address),
    .ex_rs1_used      (ex_rs1_used),
    .ex_rs2_used      (ex_rs2_used),
    .flush            (flush),
    .load_data_dm3    (load_data_dm3),
    .rd_address_dm1   (rd_address_dm1),
    .rd_address_dm2   (rd_address_dm2),
    .rd_address_dm3   (rd_address_dm3),
    .rd_address_wb    (rd_address_wb),
    .rd_data_dm1      (rd_data_dm1),
    .rd_data_dm2      (rd_data_dm2),
    .rd_data_dm3      (rd_data_dm3),
    .rd_data_wb       (rd_data_wb),
    .rf_write_en      (rf_write_en),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .stall_ex         (stall_ex),
    .stall_count      (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic ld, input logic [AW-1:0] rd,
                       input logic [DW-1:0] res, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic u1, input logic u2, input logic fl, input logic [DW-1:0] lm);
    ex_valid = v; ex_rd_write = w; ex_is_load = ld; ex_rd_address = rd; ex_result = res;
    ex_rs1_address = rs1; ex_rs2_address = rs2; ex_rs1_used = u1; ex_rs2_used = u2;
    flush = fl; load_data_dm3 = lm;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " a1"}, 32'(rd_address_dm1), 0);
    chk({tag, " a2"}, 32'(rd_address_dm2), 0);
    chk({tag, " a3"}, 32'(rd_address_dm3), 0);
    chk({tag, " aw"}, 32'(rd_address_wb), 0);
    chk({tag, " d1"}, rd_data_dm1, 0);
    chk({tag, " d2"}, rd_data_dm2, 0);
    chk({tag, " d3"}, rd_data_dm3, 0);
    chk({tag, " dw"}, rd_data_wb, 0);
    chk({tag, " we"}, 32'(rf_write_en), 0);
    chk({tag, " wa"}, 32'(rf_write_address), 0);
    chk({tag, " wd"}, rf_write_data, 0);
    chk({tag, " stall"}, 32'(stall_ex), 0);
    chk({tag, " count"}, stall_count, 0);
  endtask

  initial begin
    int exp_cnt;
    int edges;
    logic found;
    string tag;

    //          v  w  ld rd  res      rs1 rs2 u1 u2 fl lm        st a1 a2 a3 aw  d1      d2      d3       dw       we
    tbl[0]  = '{1, 1, 0, 5,  'h1234,  0,  0,  0, 0, 0, 0,        0, 0, 0, 0, 0,  0,      0,      0,       0,       0};
    tbl[1]  = '{0, 0, 0, 0,  0,       0,  0,  0, 0, 0, 0,        0, 5, 0, 0, 0,  'h1234, 0,      0,       0,       0};
    tbl[2]  = '{0, 0, 0, 0,  0,       0,  0,  0, 0, 0, 0,        0, 0, 5, 0, 0,  0,      'h1234, 0,       0,       0};
    tbl[3]  = '{0, 0, 0, 0,  0,       0,  0,  0, 0, 0, 'hFFFF,   0, 0, 0, 5, 0,  0,      0,      'h1234,  0,       0};
    tbl[4]  = '{1, 1, 1, 7,  'hDEAD,  0,  0,  0, 0, 0, 0,        0, 0, 0, 0, 5,  0,      0,      0,       'h1234,  1};
    tbl[5]  = '{1, 1, 0, 8,  'h88,    7,  3,  1, 1, 0, 0,        1, 7, 0, 0, 0,  0,      0,      0,       0,       0};
    tbl[6]  = '{1, 1, 0, 8,  'h88,    7,  3,  1, 1, 0, 0,        1, 0, 7, 0, 0,  0,      0,      0,       0,       0};
    tbl[7]  = '{1, 1, 0, 8,  'h88,    7,  3,  1, 1, 0, 'hCAFE,   0, 0, 0, 7, 0,  0,      0,      'hCAFE,  0,       0};
    tbl[8]  = '{1, 1, 1, 9,  'h5A5A,  0,  0,  0, 0, 0, 0,        0, 8, 0, 0, 7,  'h88,   0,      0,       'hCAFE,  1};
    tbl[9]  = '{1, 1, 0, 10, 'hA0,    1,  2,  1, 1, 0, 0,        0, 9, 8, 0, 0,  0,      'h88,   0,       0,       0};
    tbl[10] = '{1, 1, 0, 11, 'hB0,    4,  9,  1, 1, 0, 0,        1, 10, 9, 8, 0, 'hA0,   0,      'h88,    0,       0};
    tbl[11] = '{1, 1, 0, 11, 'hB0,    4,  9,  1, 1, 0, 'h99,     0, 0, 10, 9, 8, 0,      'hA0,   'h99,    'h88,    1};
    tbl[12] = '{1, 1, 0, 0,  'h55,    0,  0,  0, 0, 0, 'h77,     0, 11, 0, 10, 9, 'hB0,  0,      'hA0,    'h99,    1};
    tbl[13] = '{1, 1, 1, 0,  'h44,    0,  0,  0, 0, 0, 0,        0, 0, 11, 0, 10, 0,     'hB0,   0,       'hA0,    1};
    tbl[14] = '{1, 1, 0, 12, 'hC0,    0,  0,  1, 0, 0, 'h11,     0, 0, 0, 11, 0,  0,     0,      'hB0,    0,       0};
    tbl[15] = '{1, 1, 1, 7,  'h77,    0,  0,  0, 0, 0, 0,        0, 12, 0, 0, 11, 'hC0,  0,      0,       'hB0,    1};
    tbl[16] = '{1, 1, 0, 13, 'hD0,    7,  0,  1, 0, 1, 'h66,     0, 7, 12, 0, 0,  0,     'hC0,   0,       0,       0};
    tbl[17] = '{1, 1, 0, 14, 'hE0,    7,  7,  0, 0, 0, 0,        0, 0, 7, 12, 0,  0,     0,      'hC0,    0,       0};
    tbl[18] = '{0, 0, 0, 0,  0,       0,  0,  0, 0, 0, 'h3333,   0, 14, 0, 7, 12, 'hE0,  0,      'h3333,  'hC0,    1};
    tbl[19] = '{0, 0, 0, 0,  0,       0,  0,  0, 0, 0, 0,        0, 0, 14, 0, 7,  0,     'hE0,   0,       'h3333,  1};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    exp_cnt = 0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].v[0], tbl[i].w[0], tbl[i].ld[0], tbl[i].rd[AW-1:0], tbl[i].res,
            tbl[i].rs1[AW-1:0], tbl[i].rs2[AW-1:0], tbl[i].u1[0], tbl[i].u2[0],
            tbl[i].fl[0], tbl[i].lm);
      #1;
      tag = $sformatf("row%0d", i);
      chk({tag, " stall"}, 32'(stall_ex), tbl[i].st);
      chk({tag, " a1"}, 32'(rd_address_dm1), tbl[i].a1);
      chk({tag, " a2"}, 32'(rd_address_dm2), tbl[i].a2);
      chk({tag, " a3"}, 32'(rd_address_dm3), tbl[i].a3);
      chk({tag, " aw"}, 32'(rd_address_wb), tbl[i].aw);
      chk({tag, " d1"}, rd_data_dm1, tbl[i].d1);
      chk({tag, " d2"}, rd_data_dm2, tbl[i].d2);
      chk({tag, " d3"}, rd_data_dm3, tbl[i].d3);
      chk({tag, " dw"}, rd_data_wb, tbl[i].dw);
      chk({tag, " we"}, 32'(rf_write_en), tbl[i].we);
      if (tbl[i].we[0]) begin
        chk({tag, " wa"}, 32'(rf_write_address), tbl[i].aw);
        chk({tag, " wd"}, rf_write_data, tbl[i].dw);
      end
`ifdef WRITEBACK_TRACKER_STALL_COUNT_EN
      chk({tag, " count"}, stall_count, 32'(exp_cnt));
`else
      chk({tag, " count"}, stall_count, 0);
`endif
      if (tbl[i].st[0]) exp_cnt++;
    end

    // Three stall cycles came from the table
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
`ifdef WRITEBACK_TRACKER_STALL_COUNT_EN
    chk("count_before_reset", stall_count, 3);
`else
    chk("count_before_reset", stall_count, 0);
`endif

    // Three ALU ops in flight, then an asynchronous reset mid-cycle
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(1, 1, 0, AW'(k), DW'(k * 'h111), 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    drive(1, 1, 0, 4, 'h444, 1, 2, 1, 1, 0, 0);
    #1;
    chk("inflight_dm3", 32'(rd_address_dm3), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");

    // First instruction after release must reach the register file 4 edges later
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 0, 20, 'h2020, 0, 0, 0, 0, 0, 0);
    edges = 0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk);
      #1;
      edges++;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (rf_write_en) found = 1'b1;
    end
    chk("post_reset_latency", 32'(edges), 4);
    chk("post_reset_wa", 32'(rf_write_address), 20);
    chk("post_reset_wd", rf_write_data, 'h2020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_tracker.md
WRITEBACK_TRACKER -- requirements
Module: writeback_tracker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning the register address width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; the ports are: CLK  in  1  rising-edge clock; RST_N  in  1  asynchronous active-low reset.
REQ-004 SHALL have these execution-side inputs: EX_VALID  in  1  EX holds a live instruction; EX_RD_WRITE  in  1  instruction writes rd; EX_IS_LOAD  in  1  instruction is a load; EX_RD_ADDRESS  in  ADDR_WIDTH  destination register; EX_RESULT  in  DATA_WIDTH  ALU result; EX_RS1_ADDRESS, EX_RS2_ADDRESS  in  ADDR_WIDTH  source registers of the EX instruction; EX_RS1_USED, EX_RS2_USED  in  1  source operand is read; FLUSH  in  1  kill the EX instruction.
REQ-005 SHALL have this memory-side input: LOAD_DATA_DM3  in  DATA_WIDTH  data-memory read data for the load in DM3.
REQ-006 SHALL have these stage outputs: RD_ADDRESS_DM1/DM2/DM3/WB  out  ADDR_WIDTH; RD_DATA_DM1/DM2/DM3/WB  out  DATA_WIDTH.
REQ-007 SHALL have these register-file write outputs: RF_WRITE_EN  out  1; RF_WRITE_ADDRESS  out  ADDR_WIDTH; RF_WRITE_DATA  out  DATA_WIDTH.
REQ-008 SHALL have these control outputs: STALL_EX  out  1  hold EX and earlier stages; STALL_COUNT  out  32  stall-cycle count.

Function
REQ-009 SHALL keep four stage registers, DM1, DM2, DM3 and WB; each holds valid, write, is_load, rd and data, and all four advance on every rising CLK edge (STALL_EX does not freeze them).
REQ-010 SHALL load DM1 with the EX fields when EX_VALID=1, FLUSH=0 and STALL_EX=0; otherwise DM1 SHALL load a bubble (valid=0).
REQ-011 SHALL update DM2<=DM1 and DM3<=DM2 on each edge, and SHALL update WB<=DM3 with its data replaced by LOAD_DATA_DM3 when DM3 is_load=1.
REQ-012 SHALL present RD_ADDRESS_x and RD_DATA_x as 0 for any stage that is not (valid && write), so that no consumer matches against a dead stage; x0 destinations SHALL also present data 0.
REQ-013 SHALL present RD_DATA_DM1 and RD_DATA_DM2 as 0 for loads (data not yet available), and RD_DATA_DM3 as LOAD_DATA_DM3 for loads, combinationally.
REQ-014 SHALL drive STALL_EX=1 combinationally when EX_VALID=1, FLUSH=0, and a used nonzero rs1 or rs2 equals the rd of a valid, writing load in DM1 or DM2.
REQ-015 SHALL therefore stall a dependent instruction for 2 cycles behind a load in DM1 and for 1 cycle behind a load in DM2; a stall SHALL never be needed for a load in DM3 or WB.
REQ-016 SHALL drive RF_WRITE_EN = WB valid && write && rd!=0, with RF_WRITE_ADDRESS/RF_WRITE_DATA taken from the WB stage registers.
REQ-017 SHALL give FLUSH priority over a stall: when FLUSH=1, STALL_EX=0 and DM1 receives a bubble in the same cycle.

Reset
REQ-018 SHALL, while RST_N=0 (asynchronously), clear all stage valid bits, addresses and data to 0, so that every RD_* output, RF_WRITE_EN, STALL_EX and STALL_COUNT reads 0.
REQ-019 SHALL discard any in-flight instruction when reset is asserted mid-operation; the first EX instruction after reset release SHALL reach RF_WRITE_EN 4 edges later.

Configuration
REQ-020 SHALL, when macro WRITEBACK_TRACKER_STALL_COUNT_EN is defined, increment STALL_COUNT by 1 on each edge where STALL_EX=1, saturating at 32'hFFFF_FFFF.
REQ-021 SHALL, when WRITEBACK_TRACKER_STALL_COUNT_EN is not defined, keep the STALL_COUNT port and tie it to 0, with no counter flops.

Structure
REQ-022 SHALL place in the shared pipeline package: the stage-record typedef (valid, write, is_load, rd, data), the stage index constants DM1=0, DM2=1, DM3=2, WB=3, and the x0 address constant.
REQ-023 SHALL implement the stall comparator as one sub-module, load_use_detector, which is purely combinational and instantiated once.

Verification
REQ-024 SHALL cover: ALU op rd=5, data 32'h1234, no stall -> RD_ADDRESS_DM1=5 after 1 edge, DM2 after 2, DM3 after 3, and RF_WRITE_EN=1 with address 5 and data 32'h1234 after 4 edges.
REQ-025 SHALL cover: load rd=7 followed by a dependent op rs1=7 -> STALL_EX=1 for exactly 2 cycles, two bubbles in DM1, and RD_DATA_DM3=LOAD_DATA_DM3=32'hCAFE when the load reaches DM3.
REQ-026 SHALL cover: load rd=7, one independent op, then rs2=7 -> STALL_EX=1 for exactly 1 cycle.
REQ-027 SHALL cover: op with rd=0, or a load rd=0 followed by rs1=0 -> all RD_ADDRESS/RD_DATA outputs 0, RF_WRITE_EN=0, no stall.
REQ-028 SHALL cover: FLUSH=1 in a cycle where STALL_EX would be 1 -> STALL_EX=0 and DM1 is a bubble on the next edge.
REQ-029 SHALL cover: RST_N pulsed low with 3 instructions in flight -> all outputs 0 immediately; with WRITEBACK_TRACKER_STALL_COUNT_EN defined, 3 stall cycles -> STALL_COUNT=3, and reset returns it to 0.
